// File: rtl/macro_cnt_decr_pkg.sv
// macro_cnt_decr_pkg: shared constants for the credit down-counter and its decrement ROM slices.
// Revision 1.0
`default_nettype none

package macro_cnt_decr_pkg;

  localparam int SLICE_W = 3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ACTIVE    = 2'd1;
  localparam logic [1:0] ST_EXHAUSTED = 2'd2;

endpackage

`default_nettype wire

// File: rtl/macro_cnt_decr_credit_rom.sv
// macro_rom_decr3: 3-bit decrement ROM slice, q = d - 1 mod 8, b flags a borrow out (d == 0).
// Revision 1.0
`default_nettype none

module macro_rom_decr3 (
  input  logic [2:0] d,
  output logic [2:0] q,
  output logic       b
);

  always_comb begin
    q = 3'd0;
    b = 1'b0;
    case (d)
      3'd0: begin q = 3'd7; b = 1'b1; end
      3'd1: q = 3'd0;
      3'd2: q = 3'd1;
      3'd3: q = 3'd2;
      3'd4: q = 3'd3;
      3'd5: q = 3'd4;
      3'd6: q = 3'd5;
      3'd7: q = 3'd6;
      default: begin q = 3'd0; b = 1'b0; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/macro_cnt_decr_credit.sv
// macro_cnt_decr_credit: loadable credit down-counter built from cascaded 3-bit decrement ROMs.
// Optional periodic reload when MACRO_CNT_DECR_AUTO_RELOAD_EN is defined. Revision 1.0
`default_nettype none

module macro_cnt_decr_credit
  import macro_cnt_decr_pkg::*;
#(
  parameter int SLICES = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_load_valid,
  input  logic [SLICE_W*SLICES-1:0] i_load_value,
  input  logic                     i_take_valid,
  output logic                     o_take_ready,
  output logic [SLICE_W*SLICES-1:0] o_count,
  output logic                     o_zero,
  output logic                     o_done
);

  localparam int CNT_W = SLICE_W * SLICES;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count_next;
  logic             done_next;
  logic [CNT_W-1:0] decr;
  logic [SLICES:0]  en;
  logic [SLICES-1:0] borrow;
  logic             take;
  logic             last_take;

  assign take      = i_take_valid & o_take_ready;
  assign last_take = take & (o_count == CNT_ONE) & ~i_load_valid;
  assign en[0]     = take;

  // Each slice decrements only when every lower slice is at zero and borrows.
  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    logic [SLICE_W-1:0] q;

    macro_rom_decr3 u_rom (
      .d (o_count[k*SLICE_W +: SLICE_W]),
      .q (q),
      .b (borrow[k])
    );

    assign en[k+1] = en[k] & borrow[k];
    assign decr[k*SLICE_W +: SLICE_W] = en[k] ? q : o_count[k*SLICE_W +: SLICE_W];
  end

`ifdef MACRO_CNT_DECR_AUTO_RELOAD_EN
  logic [CNT_W-1:0] reload;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reload <= '0;
    end else if (i_load_valid) begin
      reload <= i_load_value;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_count <= '0;
      o_done  <= 1'b0;
    end else begin
      o_count <= count_next;
      o_done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    if (i_load_valid) begin
      state_next = (i_load_value != '0) ? ST_ACTIVE : ST_EXHAUSTED;
    end else if (last_take) begin
`ifdef MACRO_CNT_DECR_AUTO_RELOAD_EN
      state_next = ST_ACTIVE;
`else
      state_next = ST_EXHAUSTED;
`endif
    end
  end

  // A load overrides any simultaneous take; borrow out of the top slice would mean a wrap, so hold instead.
  always_comb begin
    count_next = o_count;
    done_next  = 1'b0;
    if (i_load_valid) begin
      count_next = i_load_value;
    end else if (last_take) begin
      done_next = 1'b1;
`ifdef MACRO_CNT_DECR_AUTO_RELOAD_EN
      count_next = reload;
`else
      count_next = decr;
`endif
    end else if (take && !en[SLICES]) begin
      count_next = decr;
    end
  end

  always_comb begin
    o_take_ready = (state == ST_ACTIVE);
    o_zero       = (o_count == '0);
  end

endmodule

`default_nettype wire
